// File: rtl/fib_bcd_conv_if.sv
// Handshake bundle between the Fibonacci term source and the BCD converter.
// master drives terms and consumes results; slave is the converter side.
interface fib_bcd_conv_if #(
    parameter int N      = 16,
    parameter int DIGITS = 5
);
    logic [N-1:0]        in_data;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic                out_valid;
    logic                out_ready;
    logic                ovr;
`ifdef FIB_BCD_BLANK_EN
    logic [DIGITS-1:0]   blank;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, bcd_out, out_valid, ovr, blank
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, bcd_out, out_valid, ovr, blank
    );
`else
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, bcd_out, out_valid, ovr
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, bcd_out, out_valid, ovr
    );
`endif
endinterface

// File: rtl/fib_bcd_conv.sv
// Binary-to-packed-BCD converter (double-dabble), one term in flight; FIB_BCD_BLANK_EN adds leading-zero blanking.
// Latency: term accepted at edge k gives out_valid after edge k+N; accept-to-accept spacing is N+2 cycles.
// Backpressure: result held until out_ready; terms offered while busy are dropped and set sticky ovr.
module fib_bcd_conv #(
    parameter int N      = 16,
    parameter int DIGITS = 5
) (
    input  logic           clk,
    input  logic           rst,
    fib_bcd_conv_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    sreg;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   nxt;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bcd_q;
    logic            ovr_q;

    // Add-3 on every digit >=5 so the following left shift carries correctly into the next digit.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        nxt = {adj[BW-2:0], sreg[N-1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sreg    <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= ovr_q | (bus.in_valid & (state != IDLE));
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sreg    <= bus.in_data;
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= nxt;
                    sreg    <= {sreg[N-2:0], 1'b0};
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        bcd_q <= nxt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.bcd_out   = bcd_q;
    assign bus.ovr       = ovr_q;

`ifdef FIB_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic [DIGITS-1:0] blank_q;
    logic              hi_zero;

    // Digit 0 is never blanked so a zero result still shows one digit.
    always_comb begin
        blank_nxt = '0;
        hi_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero      = hi_zero & (nxt[4*i +: 4] == 4'd0);
            blank_nxt[i] = hi_zero;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank_q <= '0;
        end else if (state == SHIFT && cnt == CW'(N - 1)) begin
            blank_q <= blank_nxt;
        end
    end

    assign bus.blank = blank_q;
`endif
endmodule

// File: tb/tb_fib_bcd_conv.sv
// Directed self-checking bench for fib_bcd_conv (N=16, DIGITS=5); blank checks follow FIB_BCD_BLANK_EN.
module tb_fib_bcd_conv;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    fib_bcd_conv_if #(.N(16), .DIGITS(5)) bus ();

    fib_bcd_conv #(.N(16), .DIGITS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    // Presents one term for a single cycle, then waits (bounded) for the result.
    task automatic send_term(input logic [15:0] v, output int lat, output logic [19:0] bcd,
                             output logic rdy_after);
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rdy_after    = bus.in_ready;
        lat = -1;
        bcd = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = c;
                bcd = bus.bcd_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid_in_reset: got=%b want=0", bus.out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got=%b want=1", bus.in_ready);
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got=%b want=0", bus.out_valid);
        end
        total++;
        if (bus.bcd_out !== 20'h00000) begin
            bad++; $display("FAIL reset_bcd_out: got=%h want=00000", bus.bcd_out);
        end
        total++;
        if (bus.ovr !== 1'b0) begin
            bad++; $display("FAIL reset_ovr: got=%b want=0", bus.ovr);
        end
`ifdef FIB_BCD_BLANK_EN
        total++;
        if (bus.blank !== 5'b00000) begin
            bad++; $display("FAIL reset_blank: got=%b want=00000", bus.blank);
        end
`endif
    endtask

    task automatic test_convert_55();
        int lat; logic [19:0] bcd; logic rdy;
        bus.out_ready = 1'b1;
        send_term(16'd55, lat, bcd, rdy);
        total++;
        if (rdy !== 1'b0) begin
            bad++; $display("FAIL c55_busy_in_ready: got=%b want=0", rdy);
        end
        total++;
        if (lat !== 16) begin
            bad++; $display("FAIL c55_latency: got=%0d want=16", lat);
        end
        total++;
        if (bcd !== 20'h00055) begin
            bad++; $display("FAIL c55_bcd: got=%h want=00055", bcd);
        end
`ifdef FIB_BCD_BLANK_EN
        total++;
        if (bus.blank !== 5'b11100) begin
            bad++; $display("FAIL c55_blank: got=%b want=11100", bus.blank);
        end
`endif
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL c55_return_idle: got out_valid=%b in_ready=%b want 0 1",
                            bus.out_valid, bus.in_ready);
        end
        total++;
        if (bus.bcd_out !== 20'h00055) begin
            bad++; $display("FAIL c55_bcd_kept: got=%h want=00055", bus.bcd_out);
        end
    endtask

    task automatic test_boundaries();
        int lat; logic [19:0] bcd; logic rdy;
        bus.out_ready = 1'b1;
        send_term(16'hFFFF, lat, bcd, rdy);
        total++;
        if (lat !== 16 || bcd !== 20'h65535) begin
            bad++; $display("FAIL max_bcd: got=%h lat=%0d want=65535 lat=16", bcd, lat);
        end
`ifdef FIB_BCD_BLANK_EN
        total++;
        if (bus.blank !== 5'b00000) begin
            bad++; $display("FAIL max_blank: got=%b want=00000", bus.blank);
        end
`endif
        @(posedge clk); #1;
        send_term(16'd0, lat, bcd, rdy);
        total++;
        if (lat !== 16 || bcd !== 20'h00000) begin
            bad++; $display("FAIL zero_bcd: got=%h lat=%0d want=00000 lat=16", bcd, lat);
        end
`ifdef FIB_BCD_BLANK_EN
        total++;
        if (bus.blank !== 5'b11110) begin
            bad++; $display("FAIL zero_blank: got=%b want=11110", bus.blank);
        end
`endif
        @(posedge clk); #1;
        send_term(16'd6765, lat, bcd, rdy);
        total++;
        if (lat !== 16 || bcd !== 20'h06765) begin
            bad++; $display("FAIL c6765_bcd: got=%h lat=%0d want=06765 lat=16", bcd, lat);
        end
`ifdef FIB_BCD_BLANK_EN
        total++;
        if (bus.blank !== 5'b10000) begin
            bad++; $display("FAIL c6765_blank: got=%b want=10000", bus.blank);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        int lat; logic [19:0] bcd; logic rdy;
        bus.out_ready = 1'b0;
        send_term(16'd1234, lat, bcd, rdy);
        total++;
        if (lat !== 16 || bcd !== 20'h01234) begin
            bad++; $display("FAIL hold_bcd: got=%h lat=%0d want=01234 lat=16", bcd, lat);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.bcd_out !== 20'h01234) begin
                bad++; $display("FAIL hold_stable[%0d]: got ov=%b ir=%b bcd=%h want 1 0 01234",
                                c, bus.out_valid, bus.in_ready, bus.bcd_out);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL hold_release: got ov=%b ir=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        total++;
        if (bus.ovr !== 1'b0) begin
            bad++; $display("FAIL hold_no_ovr: got=%b want=0", bus.ovr);
        end
    endtask

    // Generator running with en=1 every cycle: terms 1,1,2,3,5,...
    task automatic test_back_to_back();
        logic [15:0] a, b, t;
        int nres;
        int res_cyc[2];
        logic [19:0] res_bcd[2];
        a = 16'd1; b = 16'd1; nres = 0;
        bus.out_ready = 1'b1;
        for (int j = 0; j <= 35; j++) begin
            bus.in_data  = a;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            if (j == 0) begin
                total++;
                if (bus.ovr !== 1'b0) begin
                    bad++; $display("FAIL b2b_ovr_first: got=%b want=0", bus.ovr);
                end
            end
            if (j == 1) begin
                total++;
                if (bus.ovr !== 1'b1) begin
                    bad++; $display("FAIL b2b_ovr_set: got=%b want=1", bus.ovr);
                end
            end
            if (bus.out_valid) begin
                if (nres < 2) begin
                    res_cyc[nres] = j;
                    res_bcd[nres] = bus.bcd_out;
                end
                nres++;
            end
            t = a + b; a = b; b = t;
        end
        bus.in_valid = 1'b0;
        total++;
        if (nres !== 2) begin
            bad++; $display("FAIL b2b_result_count: got=%0d want=2", nres);
        end else begin
            total++;
            if (res_cyc[0] !== 16 || res_bcd[0] !== 20'h00001) begin
                bad++; $display("FAIL b2b_first: got cyc=%0d bcd=%h want cyc=16 bcd=00001",
                                res_cyc[0], res_bcd[0]);
            end
            total++;
            if (res_cyc[1] !== 34 || res_bcd[1] !== 20'h04181) begin
                bad++; $display("FAIL b2b_second: got cyc=%0d bcd=%h want cyc=34 bcd=04181",
                                res_cyc[1], res_bcd[1]);
            end
        end
        @(posedge clk); #1;
        total++;
        if (bus.ovr !== 1'b1 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_end_state: got ovr=%b ir=%b want 1 1", bus.ovr, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [19:0] bcd; logic rdy;
        bus.out_ready = 1'b1;
        bus.in_data   = 16'd9999;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL mid_busy: got in_ready=%b want=0", bus.in_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.bcd_out !== 20'h00000 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_reset: got ov=%b bcd=%h ir=%b want 0 00000 1",
                            bus.out_valid, bus.bcd_out, bus.in_ready);
        end
        total++;
        if (bus.ovr !== 1'b0) begin
            bad++; $display("FAIL mid_reset_ovr: got=%b want=0", bus.ovr);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send_term(16'd233, lat, bcd, rdy);
        total++;
        if (lat !== 16 || bcd !== 20'h00233) begin
            bad++; $display("FAIL mid_fresh: got=%h lat=%0d want=00233 lat=16", bcd, lat);
        end
`ifdef FIB_BCD_BLANK_EN
        total++;
        if (bus.blank !== 5'b11000) begin
            bad++; $display("FAIL mid_fresh_blank: got=%b want=11000", bus.blank);
        end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_convert_55();
        test_boundaries();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
